gcd_sub_engine: RTL
===================

Name: gcd_sub_engine

Overview:
- Iterative subtract-and-compare GCD unit: controller FSM plus operand registers A/B, subtractor and comparator.
- The operand select muxes (0 = external load, 1 = difference feedback) are folded into the register-load logic here.
- Upstream logic presents two unsigned operands with a start pulse. The block returns gcd(a,b) with a one-cycle done pulse and the subtraction-step count.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy=0).
- a_in  input  WIDTH  operand A; captured in the cycle start is accepted.
- b_in  input  WIDTH  operand B; captured in the cycle start is accepted.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; gcd_out/iter_cnt valid from this cycle.
- gcd_out  output  WIDTH  result register; holds until the next completion.
- iter_cnt  output  WIDTH  number of subtraction steps of the last completed computation.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; A=B=0; busy=0; done=0; gcd_out=0; iter_cnt=0. Reset overrides everything, including mid-computation; an aborted computation produces no done.
- States: IDLE, CALC.
- IDLE: if start=1 then A<=a_in, B<=b_in, internal step counter<=0, busy<=1, state<=CALC. Otherwise hold.
- CALC, evaluated once per cycle in priority order:
  - If A==0 or B==0 or A==B: gcd_out<=A|B, iter_cnt<=step counter, done<=1, busy<=0, state<=IDLE.
  - Else if A>B: A<=A-B, counter+1.
  - Else: B<=B-A, counter+1.
- The A|B rule gives gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
- Arithmetic is unsigned, WIDTH bits, with no wrap: subtraction occurs only when minuend > subtrahend. The step counter is WIDTH bits. The worst case, gcd(2^WIDTH-1, 1), needs 2^WIDTH-2 steps, so the counter never overflows.
- done is registered, high for exactly one cycle, and deasserts automatically the next cycle.
- Latency: start high in cycle 0 → done high in cycle N+2, where N = subtraction steps.
- busy is high in cycles 1..N+1, low in the done cycle.
- start while busy=1 is ignored; there is no queuing, and A/B are unaffected by a_in/b_in.
- start in the same cycle done is high: accepted, because state is already IDLE. busy rises the next cycle; gcd_out keeps the previous result until the new completion.
- gcd_out and iter_cnt change only at completion or reset.

Test Plan:
- Reset then start with a=48, b=18 in cycle 0 → busy cycles 1–5; done=1 only in cycle 6; gcd_out=6, iter_cnt=4; busy=0 in cycle 6.
- Equal operands a=b=12 → done in cycle 2, gcd_out=12, iter_cnt=0. Then a=0, b=35 → gcd_out=35, iter_cnt=0. Then a=0, b=0 → gcd_out=0.
- Worst case a=16'hFFFF, b=1 → done in cycle 65536, gcd_out=1, iter_cnt=65534. Pulse start with a=9, b=3 mid-run → ignored; the result is unchanged.
- Back-to-back: first computation a=21, b=14 (gcd 7, 2 steps). Assert start with a=100, b=75 in the done cycle → accepted; gcd_out stays 7 until the second done; then gcd_out=25, iter_cnt=3.
- Reset mid-op: start a=1000, b=3, assert rst at cycle 10 → next cycle busy=0, done=0, gcd_out=0, iter_cnt=0. A following start with a=8, b=12 completes with gcd_out=4, iter_cnt=2.
- Randomised sweep of 500 operand pairs (including zeros and max values) → gcd_out equals the reference Euclid result, iter_cnt equals the model's subtraction count, and done is always exactly one cycle wide.

Source files
------------

// File: rtl/gcd_sub_engine.sv
// gcd_sub_engine: iterative subtract-and-compare GCD unit.
//
// A start pulse accepted while idle loads both operands. Each CALC cycle
// then either finishes (one operand zero, or both equal) or replaces the
// larger operand with the difference of the two. The result and the number
// of subtraction steps are registered at completion, and done pulses for
// one cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request, sampled only while idle
//   a_in      operand A, captured when start is accepted
//   b_in      operand B, captured when start is accepted
//   busy      high while a computation is in progress
//   done      one-cycle completion pulse
//   gcd_out   result of the last completed computation
//   iter_cnt  subtraction steps of the last completed computation

module gcd_sub_engine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic {
        StIdle,
        StCalc
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] gcd_q;
    logic [WIDTH-1:0] iter_q;
    logic             busy_q;
    logic             done_q;

    // Datapath: comparator and both subtractor directions. A difference is
    // only loaded when its minuend is strictly larger, so it never wraps.
    logic             finish;
    logic             a_gt_b;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    always_comb begin
        finish  = (a_q == '0) || (b_q == '0) || (a_q == b_q);
        a_gt_b  = a_q > b_q;
        diff_ab = a_q - b_q;
        diff_ba = b_q - a_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Also reached in the done cycle, so back-to-back starts
                    // are accepted without a gap.
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (finish) begin
                        // A|B covers gcd(0,x)=x, gcd(x,0)=x and gcd(x,x)=x.
                        gcd_q   <= a_q | b_q;
                        iter_q  <= cnt_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (a_gt_b) begin
                        a_q   <= diff_ab;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        b_q   <= diff_ba;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign gcd_out  = gcd_q;
    assign iter_cnt = iter_q;

endmodule
